// File: rtl/msi_cache_controller.sv
// Two-line, direct-mapped MSI cache controller with a req/grant/ack bus port and a snoop port.
// Dirty victims are written back before the fill; snoop updates take priority over the local lookup.
module msi_cache_controller (
    input  logic       clock,
    input  logic       resetn,
    input  logic       execute_instruction,
    input  logic       instruction,
    input  logic [2:0] address,
    input  logic [3:0] data_in,
    output logic [3:0] data_out,
    output logic       done,
    output logic       miss,
    output logic       bus_req,
    input  logic       bus_grant,
    output logic [1:0] bus_op,
    output logic [2:0] bus_addr,
    output logic [3:0] bus_wdata,
    input  logic       bus_ack,
    input  logic [3:0] mem_rdata,
    input  logic       snoop_valid,
    input  logic [1:0] snoop_op,
    input  logic [2:0] snoop_addr,
    output logic       snoop_flush,
    output logic [3:0] snoop_data
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOOKUP    = 3'd1;
    localparam logic [2:0] WB_REQ    = 3'd2;
    localparam logic [2:0] WB_WAIT   = 3'd3;
    localparam logic [2:0] FILL_REQ  = 3'd4;
    localparam logic [2:0] FILL_WAIT = 3'd5;
    localparam logic [2:0] COMPLETE  = 3'd6;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_M = 2'd2;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_RDX  = 2'b10;
    localparam logic [1:0] OP_WB   = 2'b11;

    logic [2:0] state;
    logic       exec_q;
    logic       req_write;
    logic [2:0] req_addr;
    logic [3:0] req_data;

    logic [1:0] line_state [2];
    logic [1:0] line_tag   [2];
    logic [3:0] line_data  [2];

    logic idx, sidx, hit, snoop_match, snoop_to_s, snoop_to_i, lookup_blocked;

    assign idx  = req_addr[0];
    assign sidx = snoop_addr[0];
    assign hit  = (line_state[idx] != ST_I) && (line_tag[idx] == req_addr[2:1]);

    assign snoop_match = snoop_valid && (line_state[sidx] != ST_I)
                         && (line_tag[sidx] == snoop_addr[2:1]);
    assign snoop_to_s  = snoop_match && (snoop_op == OP_RD) && (line_state[sidx] == ST_M);
    assign snoop_to_i  = snoop_match && (snoop_op == OP_RDX);
    assign snoop_flush = snoop_match && (line_state[sidx] == ST_M)
                         && ((snoop_op == OP_RD) || (snoop_op == OP_RDX));
    assign snoop_data  = snoop_flush ? line_data[sidx] : '0;

    // A snoop changing the line under lookup defers the lookup by one cycle.
    assign lookup_blocked = (snoop_to_s || snoop_to_i) && (sidx == idx);

    assign done = (state == COMPLETE);

    always_comb begin
        bus_req   = 1'b0;
        bus_op    = OP_NONE;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state)
            WB_REQ, WB_WAIT: begin
                bus_req   = 1'b1;
                bus_op    = OP_WB;
                bus_addr  = {line_tag[idx], idx};
                bus_wdata = line_data[idx];
            end
            FILL_REQ, FILL_WAIT: begin
                bus_req  = 1'b1;
                bus_op   = req_write ? OP_RDX : OP_RD;
                bus_addr = req_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            exec_q    <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_data  <= '0;
            data_out  <= '0;
            miss      <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                line_state[i] <= ST_I;
                line_tag[i]   <= '0;
                line_data[i]  <= '0;
            end
        end else begin
            exec_q <= execute_instruction;

            // Snoop first; local line writes below are later and win when they occur.
            if (snoop_to_s) line_state[sidx] <= ST_S;
            if (snoop_to_i) line_state[sidx] <= ST_I;

            case (state)
                IDLE: begin
                    if (execute_instruction && !exec_q) begin
                        req_write <= instruction;
                        req_addr  <= address;
                        req_data  <= data_in;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (!lookup_blocked) begin
                        miss <= !hit;
                        if (hit) begin
                            if (!req_write) begin
                                data_out <= line_data[idx];
                                state    <= COMPLETE;
                            end else if (line_state[idx] == ST_M) begin
                                line_data[idx] <= req_data;
                                state          <= COMPLETE;
                            end else begin
                                state <= FILL_REQ;
                            end
                        end else if (line_state[idx] == ST_M) begin
                            state <= WB_REQ;
                        end else begin
                            state <= FILL_REQ;
                        end
                    end
                end
                WB_REQ:   if (bus_grant) state <= WB_WAIT;
                WB_WAIT: begin
                    if (bus_ack) begin
                        line_state[idx] <= ST_I;
                        state           <= FILL_REQ;
                    end
                end
                FILL_REQ: if (bus_grant) state <= FILL_WAIT;
                FILL_WAIT: begin
                    if (bus_ack) begin
                        line_tag[idx] <= req_addr[2:1];
                        if (req_write) begin
                            line_data[idx]  <= req_data;
                            line_state[idx] <= ST_M;
                        end else begin
                            line_data[idx]  <= mem_rdata;
                            line_state[idx] <= ST_S;
                            data_out        <= mem_rdata;
                        end
                        state <= COMPLETE;
                    end
                end
                COMPLETE: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msi_cache_controller.sv
// Directed, table-driven bench for msi_cache_controller: CPU transactions and snoops with
// hand-computed expectations, plus a reset-during-fill sequence.
module tb_msi_cache_controller;

    logic       clock = 1'b0;
    logic       resetn;
    logic       execute_instruction, instruction;
    logic [2:0] address;
    logic [3:0] data_in, data_out;
    logic       done, miss, bus_req, bus_grant, bus_ack;
    logic [1:0] bus_op;
    logic [2:0] bus_addr;
    logic [3:0] bus_wdata, mem_rdata;
    logic       snoop_valid;
    logic [1:0] snoop_op;
    logic [2:0] snoop_addr;
    logic       snoop_flush;
    logic [3:0] snoop_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    msi_cache_controller dut (
        .clock(clock), .resetn(resetn),
        .execute_instruction(execute_instruction), .instruction(instruction),
        .address(address), .data_in(data_in), .data_out(data_out),
        .done(done), .miss(miss),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_op(bus_op),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .mem_rdata(mem_rdata),
        .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
        .snoop_flush(snoop_flush), .snoop_data(snoop_data)
    );

    typedef struct {
        bit         is_snoop;
        bit         wr;
        logic [2:0] addr;
        logic [3:0] wd;
        logic [3:0] mrd;
        bit         glitch;
        bit         lk_snoop;
        bit         e_miss;
        int         e_nbus;
        logic [1:0] e_op0;
        logic [2:0] e_a0;
        logic [3:0] e_wd0;
        logic [1:0] e_op1;
        logic [2:0] e_a1;
        int         e_dcyc;
        bit         chk_dout;
        logic [3:0] e_dout;
        logic [1:0] sop;
        bit         e_flush;
        logic [3:0] e_sdata;
    } vec_t;

    vec_t tv[24];

    function automatic vec_t tx(bit wr, logic [2:0] a, logic [3:0] wd, logic [3:0] mrd,
                                bit e_miss, int e_nbus, logic [1:0] e_op0, logic [2:0] e_a0,
                                int e_dcyc, bit chk, logic [3:0] e_dout);
        vec_t v = '{default: 0};
        v.wr = wr; v.addr = a; v.wd = wd; v.mrd = mrd;
        v.e_miss = e_miss; v.e_nbus = e_nbus; v.e_op0 = e_op0; v.e_a0 = e_a0;
        v.e_dcyc = e_dcyc; v.chk_dout = chk; v.e_dout = e_dout;
        return v;
    endfunction

    function automatic vec_t sn(logic [1:0] op, logic [2:0] a, bit fl, logic [3:0] sd);
        vec_t v = '{default: 0};
        v.is_snoop = 1'b1; v.sop = op; v.addr = a; v.e_flush = fl; v.e_sdata = sd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_snoop(input int i, input vec_t v);
        @(negedge clock);
        snoop_valid = 1'b1; snoop_op = v.sop; snoop_addr = v.addr;
        #1;
        chk($sformatf("v%0d snoop_flush", i), 32'(snoop_flush), 32'(v.e_flush));
        if (v.e_flush) chk($sformatf("v%0d snoop_data", i), 32'(snoop_data), 32'(v.e_sdata));
        @(negedge clock);
        snoop_valid = 1'b0;
    endtask

    task automatic run_tx(input int i, input vec_t v);
        int nbus = 0, phase = 0, dcyc = -1, dcnt = 0, cyc = 0;
        logic [1:0] op[2];
        logic [2:0] ad[2];
        logic [3:0] wd[2];
        logic [3:0] dout = '0;
        logic       got_miss = 1'b0;
        op = '{default: '0}; ad = '{default: '0}; wd = '{default: '0};
        @(negedge clock);
        instruction = v.wr; address = v.addr; data_in = v.wd; execute_instruction = 1'b1;
        while (cyc < 40 && !(dcyc >= 0 && cyc >= dcyc + 3)) begin
            @(negedge clock);
            cyc++;
            if (v.glitch && cyc == 2) execute_instruction = 1'b0;
            if (v.glitch && cyc == 3) execute_instruction = 1'b1;
            if (v.lk_snoop && cyc == 1) begin
                snoop_valid = 1'b1; snoop_op = 2'b10; snoop_addr = v.addr;
            end
            if (v.lk_snoop && cyc == 2) snoop_valid = 1'b0;
            if (done) begin
                dcnt++;
                if (dcyc < 0) begin dcyc = cyc; dout = data_out; got_miss = miss; end
            end
            case (phase)
                0: if (bus_req) begin
                    if (nbus < 2) begin op[nbus] = bus_op; ad[nbus] = bus_addr; wd[nbus] = bus_wdata; end
                    bus_grant = 1'b1; phase = 1;
                end
                1: begin bus_grant = 1'b0; bus_ack = 1'b1; mem_rdata = v.mrd; phase = 2; end
                default: begin bus_ack = 1'b0; mem_rdata = '0; nbus++; phase = 0; end
            endcase
        end
        bus_grant = 1'b0; bus_ack = 1'b0; execute_instruction = 1'b0;
        chk($sformatf("v%0d done_cycle", i), 32'(dcyc), 32'(v.e_dcyc));
        chk($sformatf("v%0d done_pulses", i), 32'(dcnt), 32'd1);
        chk($sformatf("v%0d miss", i), 32'(got_miss), 32'(v.e_miss));
        chk($sformatf("v%0d bus_txns", i), 32'(nbus), 32'(v.e_nbus));
        if (v.e_nbus >= 1) begin
            chk($sformatf("v%0d bus_op0", i), 32'(op[0]), 32'(v.e_op0));
            chk($sformatf("v%0d bus_addr0", i), 32'(ad[0]), 32'(v.e_a0));
            if (v.e_op0 == 2'b11) chk($sformatf("v%0d bus_wdata0", i), 32'(wd[0]), 32'(v.e_wd0));
        end
        if (v.e_nbus >= 2) begin
            chk($sformatf("v%0d bus_op1", i), 32'(op[1]), 32'(v.e_op1));
            chk($sformatf("v%0d bus_addr1", i), 32'(ad[1]), 32'(v.e_a1));
        end
        if (v.chk_dout) chk($sformatf("v%0d data_out", i), 32'(dout), 32'(v.e_dout));
        @(negedge clock);
    endtask

    task automatic apply(input int i);
        if (tv[i].is_snoop) run_snoop(i, tv[i]);
        else                run_tx(i, tv[i]);
    endtask

    initial begin
        int dcnt;
        bit seen;
        tv[0]  = tx(0, 3'b101, 4'h0, 4'h6, 1, 1, 2'b01, 3'b101, 4, 1, 4'h6);
        tv[1]  = tx(0, 3'b101, 4'h0, 4'h0, 0, 0, 2'b00, 3'b000, 2, 1, 4'h6);
        tv[2]  = tx(1, 3'b101, 4'h9, 4'h0, 0, 1, 2'b10, 3'b101, 4, 0, 4'h0);
        tv[3]  = sn(2'b01, 3'b101, 1, 4'h9);
        tv[4]  = sn(2'b01, 3'b101, 0, 4'h0);
        tv[5]  = tx(1, 3'b101, 4'h9, 4'h0, 0, 1, 2'b10, 3'b101, 4, 0, 4'h0);
        tv[6]  = tx(1, 3'b011, 4'h5, 4'h0, 1, 2, 2'b11, 3'b101, 7, 0, 4'h0);
        tv[6].e_wd0 = 4'h9; tv[6].e_op1 = 2'b10; tv[6].e_a1 = 3'b011;
        tv[7]  = sn(2'b10, 3'b111, 0, 4'h0);
        tv[8]  = sn(2'b11, 3'b011, 0, 4'h0);
        tv[9]  = sn(2'b01, 3'b011, 1, 4'h5);
        tv[10] = sn(2'b10, 3'b011, 0, 4'h0);
        tv[11] = tx(0, 3'b011, 4'h0, 4'hA, 1, 1, 2'b01, 3'b011, 4, 1, 4'hA);
        tv[12] = tx(0, 3'b000, 4'h0, 4'h3, 1, 1, 2'b01, 3'b000, 4, 1, 4'h3);
        tv[12].glitch = 1'b1;
        tv[13] = tx(0, 3'b010, 4'h0, 4'h7, 1, 1, 2'b01, 3'b010, 4, 1, 4'h7);
        tv[14] = tx(1, 3'b110, 4'hC, 4'h0, 1, 1, 2'b10, 3'b110, 4, 0, 4'h0);
        tv[15] = sn(2'b10, 3'b110, 1, 4'hC);
        tv[16] = tx(0, 3'b110, 4'h0, 4'h1, 1, 1, 2'b01, 3'b110, 4, 1, 4'h1);
        tv[17] = tx(1, 3'b111, 4'h4, 4'h0, 1, 1, 2'b10, 3'b111, 4, 0, 4'h0);
        tv[18] = tx(1, 3'b111, 4'h8, 4'h0, 0, 0, 2'b00, 3'b000, 2, 0, 4'h0);
        tv[19] = sn(2'b01, 3'b111, 1, 4'h8);
        tv[20] = tx(0, 3'b111, 4'h0, 4'hE, 1, 1, 2'b01, 3'b111, 5, 1, 4'hE);
        tv[20].lk_snoop = 1'b1;
        tv[21] = tx(1, 3'b111, 4'h2, 4'h0, 0, 1, 2'b10, 3'b111, 4, 0, 4'h0);
        tv[22] = sn(2'b01, 3'b111, 0, 4'h0);
        tv[23] = tx(0, 3'b110, 4'h0, 4'h5, 1, 1, 2'b01, 3'b110, 4, 1, 4'h5);

        resetn = 1'b0; execute_instruction = 1'b0; instruction = 1'b0;
        address = '0; data_in = '0; bus_grant = 1'b0; bus_ack = 1'b0; mem_rdata = '0;
        snoop_valid = 1'b0; snoop_op = '0; snoop_addr = '0;
        repeat (3) @(negedge clock);
        chk("reset data_out", 32'(data_out), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset miss", 32'(miss), 32'd0);
        chk("reset bus_req", 32'(bus_req), 32'd0);
        chk("reset bus_op", 32'(bus_op), 32'd0);
        chk("reset snoop_flush", 32'(snoop_flush), 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 22; i++) apply(i);

        // Reset asserted while a BusRd fill is waiting for its ack.
        @(negedge clock);
        instruction = 1'b0; address = 3'b100; execute_instruction = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            if (bus_req) seen = 1'b1;
        end
        chk("rst_seq bus_req seen", 32'(seen), 32'd1);
        bus_grant = 1'b1;
        @(negedge clock);
        bus_grant = 1'b0;
        chk("rst_seq fill_wait bus_req", 32'(bus_req), 32'd1);
        chk("rst_seq fill_wait bus_op", 32'(bus_op), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_seq async bus_req", 32'(bus_req), 32'd0);
        chk("rst_seq async bus_op", 32'(bus_op), 32'd0);
        execute_instruction = 1'b0;
        dcnt = 0;
        repeat (3) begin @(negedge clock); if (done) dcnt++; end
        resetn = 1'b1;
        repeat (4) begin @(negedge clock); if (done) dcnt++; end
        chk("rst_seq no done", 32'(dcnt), 32'd0);

        for (int i = 22; i < 24; i++) apply(i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/msi_cache_controller.md
MSI_CACHE_CONTROLLER -- requirements
Module: msi_cache_controller

Interface
REQ-001 SHALL have: clock  input  1  single system clock, all state updates on its rising edge.
REQ-002 SHALL have: resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: execute_instruction  input  1  CPU request level (switch); a 0->1 transition starts one request.
REQ-004 SHALL have: instruction  input  1  0 = read, 1 = write.
REQ-005 SHALL have: address  input  3  word address; bit 0 = index (2 lines), bits 2:1 = tag.
REQ-006 SHALL have: data_in  input  4  write data.
REQ-007 SHALL have: data_out  output  4  read result, held until the next completion.
REQ-008 SHALL have: done  output  1  one-cycle completion pulse.
REQ-009 SHALL have: miss  output  1  set at lookup when the request misses; held until the next lookup.
REQ-010 SHALL have: bus_req / bus_grant  output / input  1 / 1  bus arbitration handshake.
REQ-011 SHALL have: bus_op  output  2  00 none, 01 BusRd, 10 BusRdX, 11 WriteBack.
REQ-012 SHALL have: bus_addr, bus_wdata  output  3, 4  transaction address and write-back data.
REQ-013 SHALL have: bus_ack, mem_rdata  input  1, 4  transaction complete; fill data is valid while bus_ack = 1.
REQ-014 SHALL have: snoop_valid, snoop_op, snoop_addr  input  1, 2, 3  the other cache's transaction.
REQ-015 SHALL have: snoop_flush, snoop_data  output  1, 4  supply dirty data on a snoop.

Function
REQ-016 SHALL hold 2 lines, each holding state (I/S/M), a 2-bit tag and 4-bit data, mapped direct by address[0].
REQ-017 SHALL implement FSM states IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, COMPLETE.
REQ-018 SHALL register execute_instruction and leave IDLE for LOOKUP on a detected rising edge.
REQ-019 SHALL capture instruction, address and data_in on leaving IDLE; edges outside IDLE are ignored.
REQ-020 SHALL treat a hit as line state != I and matching tag; read hit or write hit in M -> COMPLETE.
REQ-021 SHALL complete a read hit with data_out = line data and done asserted in COMPLETE.
REQ-022 SHALL make a write hit in M update the line data; a write hit in S SHALL issue BusRdX (upgrade) via FILL_REQ.
REQ-023 SHALL make a miss on a victim in M go through WB_REQ: bus_req = 1 until bus_grant.
REQ-024 SHALL then go through WB_WAIT: bus_op = 11, bus_addr = {victim tag, index}, bus_wdata = victim data, held until bus_ack.
REQ-025 SHALL make a miss on a victim in I or S go directly to FILL_REQ (silent eviction).
REQ-026 SHALL drive bus_op = 01 (read) or 10 (write) in FILL_REQ/FILL_WAIT, with the same req/grant/ack handshake.
REQ-027 SHALL, on bus_ack, write the tag; read -> data = mem_rdata, state S, data_out = mem_rdata.
REQ-028 SHALL, on bus_ack for a write, set data = latched data_in and state M.
REQ-029 SHALL keep bus_req high from the REQ state through the ack cycle; bus_op = 00 whenever bus_req = 0.
REQ-030 SHALL, in COMPLETE, pulse done for one cycle and return to IDLE.
REQ-031 SHALL, on snoop_valid with a matching valid line: BusRd on M -> snoop_flush = 1, snoop_data = line data (combinational), M->S at the edge.
REQ-032 SHALL, on snoop_valid with a matching valid line: BusRdX on S/M -> I; flush first if M. WriteBack snoops and non-matching snoops have no effect.
REQ-033 SHALL give snoop updates priority over local lookup for the same line in the same cycle; LOOKUP is then re-evaluated the next cycle.

Reset
REQ-034 SHALL, while resetn = 0: lines I, tag 0, data 0; FSM IDLE; data_out, done, miss, bus_req, snoop_flush = 0; bus_op = 00.
REQ-035 SHALL, on reset assertion mid-transaction, drop bus_req asynchronously and discard the pending request.

Verification
REQ-036 Scenario: read 3'b101 from reset, bus_ack with mem_rdata = 4'h6 -> miss = 1, BusRd, line1 S, data_out = 6, one done pulse.
REQ-037 Scenario: repeat the same read -> miss = 0, no bus_req, done 2 cycles after the edge, data_out = 6.
REQ-038 Scenario: write 4'h9 to 3'b101 (line in S) -> BusRdX, line M, data 9; then snoop BusRd to 101 -> snoop_flush = 1, snoop_data = 9, line S.
REQ-039 Scenario: line1 in M (tag 10, data 9), write 3'b011 -> WriteBack addr 101 data 9, then BusRdX 011, line M tag 01.
REQ-040 Scenario: resetn low during FILL_WAIT -> bus_req = 0 immediately; no done pulse; after release, all lines I.
